// File: rtl/lipsi_ctrl_if.sv
// Control-side bundle of the Lipsi sequencer: memory addressing, ALU control,
// run enable and the data fed back from program memory and the accumulator.
interface lipsi_ctrl_if;
  logic       en;
  logic [7:0] instr;
  logic [7:0] acc_out;
  logic [7:0] pc;
  logic [7:0] dmem_addr;
  logic       dmem_we;
  logic [3:0] alu_ctrl;
  logic       opnd_sel;
  logic       acc_we;
  logic       halted;

  modport master (
    input  en, instr, acc_out,
    output pc, dmem_addr, dmem_we, alu_ctrl, opnd_sel, acc_we, halted
  );

  modport slave (
    output en, instr, acc_out,
    input  pc, dmem_addr, dmem_we, alu_ctrl, opnd_sel, acc_we, halted
  );
endinterface

// File: rtl/lipsi_ctrl.sv
// Fetch/decode/execute sequencer for the Lipsi 8-bit accumulator machine.
// Owns PC and IR; control outputs are a combinational decode of state and opcode.
module lipsi_ctrl (
  input  logic         clk,
  input  logic         rst,
  lipsi_ctrl_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, OPND, EXEC, HALT} state_e;

  state_e     state_q;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q;
  logic [7:0] opByte;
  logic       isAluReg, isStore, isAluImm, isBranch, isShift, isHalt;
  logic       brTaken;

  // While in DECODE the opcode is still on the program-memory bus, not yet in ir.
  assign opByte   = (state_q == DECODE) ? bus.instr : ir_q;
  assign isAluReg = ~opByte[7];
  assign isStore  = (opByte[7:4] == 4'b1000);
  assign isAluImm = (opByte[7:4] == 4'b1100);
  assign isBranch = (opByte[7:4] == 4'b1101);
  assign isShift  = (opByte[7:4] == 4'b1110);
  assign isHalt   = (opByte == 8'hFF);

  always_comb begin
    brTaken = 1'b0;
    case (ir_q[1:0])
      2'b00:   brTaken = 1'b1;
      2'b10:   brTaken = (bus.acc_out == 8'h00);
      2'b11:   brTaken = (bus.acc_out != 8'h00);
      default: brTaken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (state_q)
      DECODE: pc_d = pc_q + 8'd1;
      EXEC: begin
        if (isBranch && brTaken)
          pc_d = bus.instr;
        else if (isAluImm || isBranch)
          pc_d = pc_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
    end else if (bus.en) begin
      pc_q <= pc_d;
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          ir_q <= bus.instr;
          if (isHalt)
            state_q <= HALT;
          else if (isAluReg || isShift)
            state_q <= EXEC;
          else if (isAluImm || isBranch)
            state_q <= OPND;
          else
            state_q <= FETCH;
        end
        OPND:    state_q <= EXEC;
        EXEC:    state_q <= FETCH;
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Write strobes are qualified by en so a stalled cycle never commits anything.
  always_comb begin
    bus.alu_ctrl  = 4'b0000;
    bus.opnd_sel  = 1'b0;
    bus.acc_we    = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.dmem_addr = 8'h00;
    case (state_q)
      DECODE: begin
        if (isAluReg || isStore)
          bus.dmem_addr = {4'h0, opByte[3:0]};
        if (isStore)
          bus.dmem_we = bus.en;
      end
      EXEC: begin
        if (isAluReg) begin
          bus.alu_ctrl  = {1'b1, opByte[6:4]};
          bus.dmem_addr = {4'h0, opByte[3:0]};
          bus.acc_we    = bus.en;
        end else if (isAluImm) begin
          bus.alu_ctrl = {1'b1, opByte[2:0]};
          bus.opnd_sel = 1'b1;
          bus.acc_we   = bus.en;
        end else if (isShift) begin
          bus.alu_ctrl = {2'b01, opByte[1:0]};
          bus.acc_we   = bus.en;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc     = pc_q;
  assign bus.halted = (state_q == HALT);

endmodule

// File: tb/tb_lipsi_ctrl.sv
// Bench for lipsi_ctrl: surrounds the sequencer with program/data memories and an
// accumulator, and checks its strobes against an instruction-level reference model.
module tb_lipsi_ctrl;

  typedef struct packed {
    logic       isStore;
    logic [3:0] aluCtrl;
    logic       opndSel;
    logic [7:0] addr;
    logic [7:0] pc;
    logic [7:0] acc;
  } evt_t;

  logic       clk;
  logic       rst;
  logic [7:0] pmem     [256];
  logic [7:0] dmemInit [256];
  logic [7:0] dmem     [256];
  logic [7:0] instrQ;
  logic [7:0] dRd;
  logic [7:0] acc;
  evt_t       expQ [$];
  evt_t       monE;
  int         compared;
  int         mismatched;

  lipsi_ctrl_if bus ();

  lipsi_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.instr   = instrQ;
  assign bus.acc_out = acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] aluFn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      4'b1000: return a + b;
      4'b1001: return a - b;
      4'b1010: return a & b;
      4'b1011: return a | b;
      4'b1100: return a ^ b;
      4'b1101: return b;
      4'b1110: return a + b + 8'd1;
      4'b1111: return ~a;
      4'b0100: return {a[6:0], 1'b0};
      4'b0101: return {1'b0, a[7:1]};
      4'b0110: return {a[6:0], a[7]};
      4'b0111: return {a[0], a[7:1]};
      default: return a;
    endcase
  endfunction

  // Memories and accumulator the sequencer drives; data memory reloads during reset.
  always @(posedge clk) begin
    instrQ <= pmem[bus.pc];
    dRd    <= dmem[bus.dmem_addr];
    if (rst) begin
      acc <= 8'h00;
      for (int i = 0; i < 256; i++) dmem[i] <= dmemInit[i];
    end else begin
      if (bus.dmem_we) dmem[bus.dmem_addr] <= acc;
      if (bus.acc_we) acc <= aluFn(bus.alu_ctrl, acc, bus.opnd_sel ? instrQ : dRd);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe the sequencer raises must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (bus.acc_we === 1'b1 || bus.dmem_we === 1'b1)) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedStrobe: got acc_we=%0b dmem_we=%0b, expected no strobe (pc=0x%0h)",
                 bus.acc_we, bus.dmem_we, bus.pc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("evKind", {30'd0, bus.dmem_we, bus.acc_we}, monE.isStore ? 32'd2 : 32'd1);
        checkOutput("evAluCtrl", bus.alu_ctrl, monE.aluCtrl);
        checkOutput("evOpndSel", bus.opnd_sel, monE.opndSel);
        checkOutput("evDmemAddr", bus.dmem_addr, monE.addr);
        checkOutput("evPc", bus.pc, monE.pc);
        checkOutput("evAcc", bus.acc_out, monE.acc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e);
    bus.en = e;
    #1;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      pmem[i]     = 8'h90;
      dmemInit[i] = 8'h00;
    end
  endtask

  task automatic doReset();
    bus.en = 1'b0;
    rst    = 1'b1;
    #1;
    checkOutput("rstPc", bus.pc, 8'h00);
    checkOutput("rstHalted", bus.halted, 1'b0);
    checkOutput("rstAccWe", bus.acc_we, 1'b0);
    checkOutput("rstDmemWe", bus.dmem_we, 1'b0);
    checkOutput("rstAluCtrl", bus.alu_ctrl, 4'h0);
    checkOutput("rstDmemAddr", bus.dmem_addr, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: interprets the program at instruction level from reset,
  // queues the expected strobe events, then runs the DUT for the same number of
  // enabled cycles (cycle counts per instruction class) and compares the end state.
  task automatic runProgram(input int maxInstr, input int enPct, output logic [7:0] endPc);
    logic [7:0] mPc, mAcc, op, pc1, nxt;
    logic [7:0] mMem [256];
    logic       mHalt, taken;
    int         cycles, cnt, guard;
    evt_t       ev;
    mPc = 8'h00; mAcc = 8'h00; mHalt = 1'b0; cycles = 0;
    for (int i = 0; i < 256; i++) mMem[i] = dmemInit[i];
    for (int n = 0; n < maxInstr && !mHalt; n++) begin
      op  = pmem[mPc];
      pc1 = mPc + 8'd1;
      nxt = pmem[pc1];
      if (!op[7]) begin
        ev = '{isStore: 1'b0, aluCtrl: {1'b1, op[6:4]}, opndSel: 1'b0, addr: {4'h0, op[3:0]}, pc: pc1, acc: mAcc};
        expQ.push_back(ev);
        mAcc = aluFn(ev.aluCtrl, mAcc, mMem[op[3:0]]);
        mPc = pc1; cycles += 3;
      end else if (op[7:4] == 4'h8) begin
        ev = '{isStore: 1'b1, aluCtrl: 4'h0, opndSel: 1'b0, addr: {4'h0, op[3:0]}, pc: mPc, acc: mAcc};
        expQ.push_back(ev);
        mMem[op[3:0]] = mAcc;
        mPc = pc1; cycles += 2;
      end else if (op[7:4] == 4'hC) begin
        ev = '{isStore: 1'b0, aluCtrl: {1'b1, op[2:0]}, opndSel: 1'b1, addr: 8'h00, pc: pc1, acc: mAcc};
        expQ.push_back(ev);
        mAcc = aluFn(ev.aluCtrl, mAcc, nxt);
        mPc = pc1 + 8'd1; cycles += 4;
      end else if (op[7:4] == 4'hD) begin
        case (op[1:0])
          2'b00:   taken = 1'b1;
          2'b10:   taken = (mAcc == 8'h00);
          2'b11:   taken = (mAcc != 8'h00);
          default: taken = 1'b0;
        endcase
        mPc = taken ? nxt : pc1 + 8'd1; cycles += 4;
      end else if (op[7:4] == 4'hE) begin
        ev = '{isStore: 1'b0, aluCtrl: {2'b01, op[1:0]}, opndSel: 1'b0, addr: 8'h00, pc: pc1, acc: mAcc};
        expQ.push_back(ev);
        mAcc = aluFn(ev.aluCtrl, mAcc, 8'h00);
        mPc = pc1; cycles += 3;
      end else if (op == 8'hFF) begin
        mHalt = 1'b1; mPc = pc1; cycles += 2;
      end else begin
        mPc = pc1; cycles += 2;
      end
    end
    cnt = 0; guard = 0;
    while (cnt < cycles && guard < 20000) begin
      bus.en = ($urandom_range(1, 100) <= enPct);
      if (bus.en) cnt++;
      tick();
      guard++;
    end
    bus.en = 1'b0;
    if (guard >= 20000) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL runBudget: got %0d enabled cycles, expected %0d", cnt, cycles);
    end
    #1;
    checkOutput("endPc", bus.pc, mPc);
    checkOutput("endHalted", bus.halted, mHalt);
    checkOutput("queueEmpty", expQ.size(), 0);
    if (mHalt) begin
      for (int k = 0; k < 4; k++) begin
        bus.en = k[0];
        tick();
        checkOutput("haltStays", bus.halted, 1'b1);
        checkOutput("haltPc", bus.pc, mPc);
      end
    end
    expQ.delete();
    endPc = mPc;
  endtask

  function automatic logic [7:0] genByte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30)      return {1'b0, 7'($urandom)};
    else if (r < 45) return {4'h8, 4'($urandom)};
    else if (r < 57) return {4'hC, 4'($urandom)};
    else if (r < 70) return {4'hD, 4'($urandom)};
    else if (r < 82) return {4'hE, 4'($urandom)};
    else if (r < 97) return 8'h90 + 8'($urandom_range(0, 47));
    else             return 8'hFF;
  endfunction

  initial begin
    logic [7:0] endPc;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bus.en     = 1'b0;

    // ALU-reg with a 3-cycle stall in EXEC, then exactly one accumulator write.
    clearMem();
    pmem[0] = 8'h03; dmemInit[3] = 8'h05;
    doReset();
    applyStimulus(1'b1);
    checkOutput("fetchPc", bus.pc, 8'h00);
    checkOutput("fetchAccWe", bus.acc_we, 1'b0);
    tick();
    checkOutput("decodeDmemAddr", bus.dmem_addr, 8'h03);
    checkOutput("decodeDmemWe", bus.dmem_we, 1'b0);
    checkOutput("decodeAccWe", bus.acc_we, 1'b0);
    tick();
    checkOutput("decodePcInc", bus.pc, 8'h01);
    expQ.push_back('{isStore: 1'b0, aluCtrl: 4'b1000, opndSel: 1'b0, addr: 8'h03, pc: 8'h01, acc: 8'h00});
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0);
      checkOutput("stallAccWe", bus.acc_we, 1'b0);
      checkOutput("stallAluCtrl", bus.alu_ctrl, 4'b1000);
      checkOutput("stallDmemAddr", bus.dmem_addr, 8'h03);
      tick();
    end
    applyStimulus(1'b1);
    checkOutput("execAccWe", bus.acc_we, 1'b1);
    checkOutput("execOpndSel", bus.opnd_sel, 1'b0);
    tick();
    checkOutput("nextFetchPc", bus.pc, 8'h01);
    checkOutput("nextFetchAluCtrl", bus.alu_ctrl, 4'h0);
    checkOutput("stallQueueEmpty", expQ.size(), 0);
    bus.en = 1'b0;

    // Reset during EXEC aborts the write and restarts from address 0.
    doReset();
    applyStimulus(1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abortAccWe", bus.acc_we, 1'b0);
    checkOutput("abortPc", bus.pc, 8'h00);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("restartPc", bus.pc, 8'h00);
    runProgram(1, 100, endPc);

    clearMem();
    pmem[0] = 8'hC1; pmem[1] = 8'h0F;
    doReset(); runProgram(1, 100, endPc);
    checkOutput("immPc", endPc, 8'h02);

    clearMem();
    pmem[0] = 8'hD2; pmem[1] = 8'h40;
    doReset(); runProgram(1, 100, endPc);
    checkOutput("brzTakenPc", bus.pc, 8'h40);

    clearMem();
    pmem[0] = 8'hC5; pmem[1] = 8'h01; pmem[2] = 8'hD2; pmem[3] = 8'h40;
    doReset(); runProgram(2, 100, endPc);
    checkOutput("brzNotTakenPc", bus.pc, 8'h04);

    clearMem();
    pmem[0] = 8'hD0; pmem[1] = 8'hFE; pmem[8'hFE] = 8'hD0; pmem[8'hFF] = 8'h10;
    doReset(); runProgram(2, 100, endPc);
    checkOutput("brWrapPc", bus.pc, 8'h10);

    clearMem();
    pmem[0] = 8'hC5; pmem[1] = 8'hA5; pmem[2] = 8'h87;
    doReset(); runProgram(2, 100, endPc);

    clearMem();
    pmem[0] = 8'hD0; pmem[1] = 8'hFF; pmem[8'hFF] = 8'h90;
    doReset(); runProgram(2, 100, endPc);
    checkOutput("nopWrapPc", bus.pc, 8'h00);

    clearMem();
    pmem[0] = 8'hFF;
    doReset(); runProgram(3, 60, endPc);
    checkOutput("haltSet", bus.halted, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("haltClearedByRst", bus.halted, 1'b0);

    // Random programs with random run-enable gaps.
    for (int p = 0; p < 24; p++) begin
      for (int i = 0; i < 256; i++) begin
        pmem[i]     = genByte();
        dmemInit[i] = 8'($urandom);
      end
      doReset();
      runProgram(40, $urandom_range(60, 100), endPc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
